// File: rtl/rs_ff_sequencer_if.sv
// Requester handshake bundle for rs_ff_sequencer.
//   req0/req1 : level requests, held by each requester until its grant
//   op0/op1   : requested operation, 1 = set, 0 = clear
//   gnt0/gnt1 : one-cycle grants back to the requesters
// master = requester side, slave = sequencer side.
interface rs_ff_sequencer_if;
    logic req0;
    logic op0;
    logic req1;
    logic op1;
    logic gnt0;
    logic gnt1;

    modport master (
        output req0, op0, req1, op1,
        input  gnt0, gnt1
    );

    modport slave (
        input  req0, op0, req1, op1,
        output gnt0, gnt1
    );
endinterface

// File: rtl/rs_ff_sequencer.sv
// Sole driver of an RS flip-flop's Set/Reset inputs. Arbitrates two
// requesters round-robin, issues a fixed-width Set or Reset pulse, inserts a
// guard gap, and checks the flip-flop's Q against the requested operation.
//
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   req_if   : requester bundle (req/op in, gnt out)
//   q        : Q feedback from the flip-flop
//   ff_set   : flip-flop Set drive
//   ff_reset : flip-flop Reset drive
//   busy     : high whenever not IDLE
//   done     : one-cycle pulse in the first cycle after a pulse ends
//   mismatch : sticky, Q disagreed with the operation in a done cycle
//
// state | meaning
// IDLE  | no operation in progress, arbitrating
// PULSE | driving ff_set or ff_reset, cnt runs 1..PULSE_CYCLES
// GAP   | guard interval, cnt runs 1..GAP_CYCLES
module rs_ff_sequencer #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic              clock,
    input  logic              reset,
    rs_ff_sequencer_if.slave  req_if,
    input  logic              q,
    output logic              ff_set,
    output logic              ff_reset,
    output logic              busy,
    output logic              done,
    output logic              mismatch
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES);

    state_t     state;
    logic [3:0] cnt;
    logic       pri;        // 1: requester 1 wins a tie
    logic       op_latched;
    logic       win1;
    logic       win_op;

    always_comb begin
        win1   = 1'b0;
        win_op = 1'b0;
        win1   = req_if.req1 && (!req_if.req0 || pri);
        win_op = win1 ? req_if.op1 : req_if.op0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            pri         <= 1'b0;
            op_latched  <= 1'b0;
            req_if.gnt0 <= 1'b0;
            req_if.gnt1 <= 1'b0;
            ff_set      <= 1'b0;
            ff_reset    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mismatch    <= 1'b0;
        end else begin
            req_if.gnt0 <= 1'b0;
            req_if.gnt1 <= 1'b0;
            done        <= 1'b0;

            // done is registered, so this compares Q during the done cycle
            // against the op of the pulse that just ended, even if a new
            // grant relatches op_latched on this same edge.
            if (done && (q != op_latched)) begin
                mismatch <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req_if.req0 || req_if.req1) begin
                        state       <= PULSE;
                        cnt         <= 4'd1;
                        busy        <= 1'b1;
                        req_if.gnt0 <= !win1;
                        req_if.gnt1 <= win1;
                        pri         <= !win1;
                        op_latched  <= win_op;
                        ff_set      <= win_op;
                        ff_reset    <= !win_op;
                    end
                end
                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        ff_set   <= 1'b0;
                        ff_reset <= 1'b0;
                        done     <= 1'b1;
                        if (GAP_LAST == 4'd0) begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                            cnt   <= 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= 4'd0;
                    ff_set   <= 1'b0;
                    ff_reset <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rs_ff_sequencer.sv
// Bench for rs_ff_sequencer: three parameter sets run side by side, each with
// its own requesters, RS flip-flop model, transaction-level reference model
// and scoreboard monitor.
`timescale 1ns/1ps
module tb_rs_ff_sequencer;
    bit clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit fin [3];
    bit all_done = 1'b0;

    typedef struct {
        int who;
        bit op;
        int g;      // cycle in which the grant is expected
    } txn_t;

    task automatic check(input int cfg, input string name,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h, expected %0h", cfg, name, got, want);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int P = (gi == 0) ? 2 : (gi == 1) ? 4 : 1;
        localparam int G = (gi == 0) ? 1 : (gi == 1) ? 2 : 0;

        logic rst = 1'b1;
        logic q = 1'b0;
        logic q_stuck = 1'b0;
        logic q_stuck_val = 1'b0;
        logic ff_set, ff_reset, busy, done, mismatch;
        int   m0 = 0, m1 = 0;       // 0 off, 1 random, 2 hold, 3 one-shot
        bit   hop0 = 1'b0, hop1 = 1'b0;
        bit   fired0 = 1'b0, fired1 = 1'b0;

        rs_ff_sequencer_if rif ();

        rs_ff_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
            .clock    (clock),
            .reset    (rst),
            .req_if   (rif),
            .q        (q),
            .ff_set   (ff_set),
            .ff_reset (ff_reset),
            .busy     (busy),
            .done     (done),
            .mismatch (mismatch)
        );

        // RS flip-flop model, settles one cycle after a Set/Reset cycle.
        always @(posedge clock) begin
            if (q_stuck)       q <= q_stuck_val;
            else if (ff_set)   q <= 1'b1;
            else if (ff_reset) q <= 1'b0;
        end

        // Requesters: hold a request until granted.
        initial begin
            rif.req0 = 1'b0; rif.op0 = 1'b0;
            rif.req1 = 1'b0; rif.op1 = 1'b0;
            forever begin
                @(negedge clock); #1;
                if (rif.gnt0) rif.req0 = 1'b0;
                if (rif.gnt1) rif.req1 = 1'b0;
                if (m0 != 3) fired0 = 1'b0;
                if (m1 != 3) fired1 = 1'b0;
                case (m0)
                    0: rif.req0 = 1'b0;
                    1: if (!rif.req0 && $urandom_range(0, 2) == 0) begin
                           rif.req0 = 1'b1;
                           rif.op0  = 1'($urandom_range(0, 1));
                       end
                    2: if (!rif.req0) begin rif.req0 = 1'b1; rif.op0 = hop0; end
                    default: if (!fired0) begin
                           rif.req0 = 1'b1; rif.op0 = hop0; fired0 = 1'b1;
                       end
                endcase
                case (m1)
                    0: rif.req1 = 1'b0;
                    1: if (!rif.req1 && $urandom_range(0, 2) == 0) begin
                           rif.req1 = 1'b1;
                           rif.op1  = 1'($urandom_range(0, 1));
                       end
                    2: if (!rif.req1) begin rif.req1 = 1'b1; rif.op1 = hop1; end
                    default: if (!fired1) begin
                           rif.req1 = 1'b1; rif.op1 = hop1; fired1 = 1'b1;
                       end
                endcase
            end
        end

        // Reference model: a schedule of transactions. A grant issued in
        // cycle g owns cycles g..g+P+G-1 (pulse g..g+P-1, done at g+P) and the
        // sequencer is free to sample requests again from cycle g+P+G.
        txn_t exp_q [$];
        int   now = 0;
        int   free_at = 0;
        int   epoch = 0;
        bit   ptr = 1'b0;           // requester favoured on a tie
        bit   exp_mm = 1'b0;
        bit   last_valid = 1'b0;
        int   last_g = 0;
        bit   last_op = 1'b0;
        int   who;
        bit   op;

        initial forever begin
            @(posedge clock);
            now++;
            if (rst) begin
                exp_q.delete();
                free_at    = now;
                ptr        = 1'b0;
                exp_mm     = 1'b0;
                last_valid = 1'b0;
                epoch++;
            end else begin
                if (last_valid && (now - 1 == last_g + P) && (q != last_op))
                    exp_mm = 1'b1;
                if ((now - 1 >= free_at) && (rif.req0 || rif.req1)) begin
                    if (rif.req0 && rif.req1) who = int'(ptr);
                    else                      who = rif.req1 ? 1 : 0;
                    op = (who == 1) ? rif.op1 : rif.op0;
                    exp_q.push_back('{who, op, now});
                    last_valid = 1'b1;
                    last_g     = now;
                    last_op    = op;
                    free_at    = now + P + G;
                    ptr        = (who == 0);
                end
            end
        end

        // Scoreboard monitor.
        txn_t act;
        bit   act_valid = 1'b0;
        int   act_epoch = 0;
        logic [6:0] got_v, exp_v;
        logic in_pulse;

        initial forever begin
            @(negedge clock);
            if (now > 0) begin
                if (act_epoch != epoch) act_valid = 1'b0;
                if (rif.gnt0 || rif.gnt1) begin
                    if (exp_q.size() == 0) begin
                        check(gi, "spurious_grant", {rif.gnt0, rif.gnt1}, 2'b00);
                    end else begin
                        act = exp_q.pop_front();
                        act_valid = 1'b1;
                        act_epoch = epoch;
                        check(gi, "grant_who", {rif.gnt0, rif.gnt1},
                              (act.who == 1) ? 2'b01 : 2'b10);
                        check(gi, "grant_cycle", now, act.g);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].g <= now) begin
                    check(gi, "missing_grant", {rif.gnt0, rif.gnt1},
                          (exp_q[0].who == 1) ? 2'b01 : 2'b10);
                    act = exp_q.pop_front();
                    act_valid = 1'b1;
                    act_epoch = epoch;
                end

                exp_v = {6'b0, exp_mm};
                if (act_valid) begin
                    in_pulse = (now >= act.g) && (now < act.g + P);
                    exp_v[6] = (now == act.g) && (act.who == 0);
                    exp_v[5] = (now == act.g) && (act.who == 1);
                    exp_v[4] = in_pulse && act.op;
                    exp_v[3] = in_pulse && !act.op;
                    exp_v[2] = (now >= act.g) && (now < act.g + P + G);
                    exp_v[1] = (now == act.g + P);
                end
                got_v = {rif.gnt0, rif.gnt1, ff_set, ff_reset, busy, done, mismatch};
                check(gi, "outputs{g0,g1,set,rst,busy,done,mm}", got_v, exp_v);
                check(gi, "set_reset_exclusive", ff_set & ff_reset, 1'b0);
            end
        end

        // Stimulus.
        bit seen;
        initial begin
            // reset held 3 cycles with req0 pending
            rst = 1'b1; m0 = 2; hop0 = 1'b1; m1 = 0;
            repeat (3) @(negedge clock);
            rst = 1'b0;
            repeat (12) @(negedge clock);

            // continuous contention, set vs clear
            m0 = 2; hop0 = 1'b1; m1 = 2; hop1 = 1'b0;
            repeat (24) @(negedge clock);

            // requester 1 alone, back-to-back clears
            m0 = 0; m1 = 2; hop1 = 1'b0;
            repeat (12) @(negedge clock);
            m1 = 0;
            repeat (P + G + 4) @(negedge clock);

            // Q stuck low through a set, then a clean clear
            q_stuck = 1'b1; q_stuck_val = 1'b0;
            m0 = 3; hop0 = 1'b1;
            repeat (P + G + 5) @(negedge clock);
            q_stuck = 1'b0; m0 = 0;
            m1 = 3; hop1 = 1'b0;
            repeat (P + G + 5) @(negedge clock);
            m1 = 0;
            repeat (2) @(negedge clock);

            // reset in the first pulse cycle
            m0 = 3; hop0 = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge clock);
                if (rif.gnt0) seen = 1'b1;
            end
            if (!seen) begin
                errors++;
                $display("FAIL cfg%0d mid_pulse_wait: got no gnt0 in 30 cycles, expected one", gi);
            end else begin
                rst = 1'b1;
                @(negedge clock);
                rst = 1'b0;
            end
            m0 = 0;
            repeat (2) @(negedge clock);

            // simultaneous arrival right after reset: requester 0 must win
            m0 = 3; hop0 = 1'b0; m1 = 3; hop1 = 1'b1;
            repeat (2 * (P + G + 2)) @(negedge clock);
            m0 = 0; m1 = 0;
            repeat (2) @(negedge clock);

            // random traffic with occasional reset and Q faults
            m0 = 1; m1 = 1;
            repeat (300) begin
                @(negedge clock);
                if ($urandom_range(0, 99) == 0) begin
                    rst = 1'b1;
                    @(negedge clock);
                    rst = 1'b0;
                end
                if ($urandom_range(0, 29) == 0) begin
                    q_stuck     = !q_stuck;
                    q_stuck_val = 1'($urandom_range(0, 1));
                end
            end
            m0 = 0; m1 = 0; q_stuck = 1'b0;
            repeat (P + G + 6) @(negedge clock);
            fin[gi] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 5000 && !all_done; i++) begin
            @(negedge clock);
            all_done = fin[0] && fin[1] && fin[2];
        end
        if (!all_done) begin
            errors++;
            $display("FAIL timeout: got unfinished stimulus after 5000 cycles, expected completion");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
